// File: rtl/mem_arbiter_if.sv
// Simple request/grant memory bus shared by the fetch port, the load/store port and the RAM port.
//   master modport : initiator side, drives req/we/be/addr/wdata, receives gnt/rvalid/rdata
//   slave  modport : target side, the mirror image of master
// One transaction is in flight per port. gnt accepts the request in the cycle it is asserted;
// rvalid returns read data or a write ack in a later cycle.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter: instruction fetch (read-only) and load/store share one
// RAM port. Load/store has fixed priority; fetch is forced through after STARVE_MAX consecutive
// load/store grants while it waits. One transaction is outstanding at a time, but a new one may
// issue in the same cycle the previous response returns.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset; all outputs are forced to 0 while low
//   if_port     : fetch port (slave side); we/be/wdata are not used
//   ls_port     : load/store port (slave side)
//   mem_port    : RAM port (master side)
//   hold_flag_o : fetch is requesting but not granted this cycle
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        if_port,
  mem_arbiter_if.slave        ls_port,
  mem_arbiter_if.master       mem_port,
  output logic                hold_flag_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic {StIdle, StWaitRsp} state_e;
  typedef enum logic {OwnIf, OwnLs} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       store_q, store_d;
  logic [3:0] starve_q, starve_d;

  logic rsp_done;
  logic issue_ok;
  logic sel_if, sel_ls;
  logic handshake;

  // The fetch port never writes.
  logic unused_if_wr;
  assign unused_if_wr = ^{if_port.we, if_port.be, if_port.wdata};

  always_comb begin
    // Defaults
    state_d          = state_q;
    owner_d          = owner_q;
    store_d          = store_q;
    starve_d         = starve_q;
    rsp_done         = 1'b0;
    issue_ok         = 1'b0;
    sel_if           = 1'b0;
    sel_ls           = 1'b0;
    handshake        = 1'b0;
    mem_port.req     = 1'b0;
    mem_port.we      = 1'b0;
    mem_port.be      = '0;
    mem_port.addr    = '0;
    mem_port.wdata   = '0;
    if_port.gnt      = 1'b0;
    if_port.rvalid   = 1'b0;
    if_port.rdata    = '0;
    ls_port.gnt      = 1'b0;
    ls_port.rvalid   = 1'b0;
    ls_port.rdata    = '0;
    hold_flag_o      = 1'b0;

    // Outputs are held at zero for the whole reset interval, not just after the edge.
    if (rst) begin
      rsp_done = (state_q == StWaitRsp) && mem_port.rvalid;
      issue_ok = (state_q == StIdle) || rsp_done;

      // Fetch wins only once load/store has used up its allowance of consecutive grants.
      sel_ls = issue_ok && ls_port.req && !(if_port.req && (starve_q == StarveMax));
      sel_if = issue_ok && if_port.req && !sel_ls;

      if (sel_ls) begin
        mem_port.req   = 1'b1;
        mem_port.we    = ls_port.we;
        mem_port.be    = ls_port.be;
        mem_port.addr  = ls_port.addr;
        mem_port.wdata = ls_port.wdata;
      end else if (sel_if) begin
        mem_port.req   = 1'b1;
        mem_port.be    = '1;
        mem_port.addr  = if_port.addr;
      end

      if_port.gnt = sel_if && mem_port.gnt;
      ls_port.gnt = sel_ls && mem_port.gnt;
      handshake   = mem_port.req && mem_port.gnt;

      // Routing uses the registered owner, so a same-cycle new grant cannot steal this response.
      if (rsp_done) begin
        if (owner_q == OwnIf) begin
          if_port.rvalid = 1'b1;
          if_port.rdata  = mem_port.rdata;
        end else begin
          ls_port.rvalid = 1'b1;
          ls_port.rdata  = store_q ? '0 : mem_port.rdata;
        end
      end

      hold_flag_o = if_port.req && !if_port.gnt;

      if (handshake) begin
        state_d = StWaitRsp;
        owner_d = sel_ls ? OwnLs : OwnIf;
        store_d = sel_ls && ls_port.we;
      end else if (rsp_done) begin
        state_d = StIdle;
      end

      if (!if_port.req || (handshake && sel_if)) begin
        starve_d = '0;
      end else if (handshake && sel_ls && (starve_q < StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      store_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      store_q  <= store_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the RAM, drives inputs
// #1 after each rising edge and checks combinational outputs before the next edge.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic hold_flag;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ls_bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .if_port    (if_bus),
    .ls_port    (ls_bus),
    .mem_port   (mem_bus),
    .hold_flag_o(hold_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " mem_req"}, 64'(mem_bus.req), 64'd0);
    check_eq({tag, " mem_addr"}, 64'(mem_bus.addr), 64'd0);
    check_eq({tag, " mem_be"}, 64'(mem_bus.be), 64'd0);
    check_eq({tag, " if_gnt"}, 64'(if_bus.gnt), 64'd0);
    check_eq({tag, " ls_gnt"}, 64'(ls_bus.gnt), 64'd0);
    check_eq({tag, " if_rvalid"}, 64'(if_bus.rvalid), 64'd0);
    check_eq({tag, " ls_rvalid"}, 64'(ls_bus.rvalid), 64'd0);
    check_eq({tag, " hold"}, 64'(hold_flag), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst            = 1'b0;
    if_bus.req     = 1'b1;
    if_bus.we      = 1'b0;
    if_bus.be      = '0;
    if_bus.addr    = 32'h0000_0100;
    if_bus.wdata   = '0;
    ls_bus.req     = 1'b1;
    ls_bus.we      = 1'b0;
    ls_bus.be      = 4'hF;
    ls_bus.addr    = 32'h0000_3000;
    ls_bus.wdata   = '0;
    mem_bus.gnt    = 1'b1;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hAAAA_5555;

    // Reset holds every output low even with all requests active.
    #1;
    check_all_zero("reset");
    step();
    check_all_zero("reset2");

    // Release: load/store has priority on the first grant.
    rst = 1'b1;
    mem_bus.rvalid = 1'b0;
    #1;
    check_eq("rel ls_gnt", 64'(ls_bus.gnt), 64'd1);
    check_eq("rel if_gnt", 64'(if_bus.gnt), 64'd0);
    check_eq("rel hold", 64'(hold_flag), 64'd1);
    check_eq("rel mem_addr", 64'(mem_bus.addr), 64'h3000);
    step();
    if_bus.req = 1'b0;
    ls_bus.req = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h0000_1234;
    #1;
    check_eq("rel ls_rvalid", 64'(ls_bus.rvalid), 64'd1);
    check_eq("rel ls_rdata", 64'(ls_bus.rdata), 64'h1234);
    check_eq("rel if_rvalid", 64'(if_bus.rvalid), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    // Single fetch.
    if_bus.req  = 1'b1;
    if_bus.addr = 32'h0000_0100;
    #1;
    check_eq("fetch if_gnt", 64'(if_bus.gnt), 64'd1);
    check_eq("fetch mem_addr", 64'(mem_bus.addr), 64'h100);
    check_eq("fetch mem_we", 64'(mem_bus.we), 64'd0);
    check_eq("fetch mem_be", 64'(mem_bus.be), 64'hF);
    check_eq("fetch hold", 64'(hold_flag), 64'd0);
    step();
    if_bus.req     = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h0050_0093;
    #1;
    check_eq("fetch if_rvalid", 64'(if_bus.rvalid), 64'd1);
    check_eq("fetch if_rdata", 64'(if_bus.rdata), 64'h0050_0093);
    check_eq("fetch ls_rvalid", 64'(ls_bus.rvalid), 64'd0);
    check_eq("fetch mem_req idle", 64'(mem_bus.req), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    // Store with partial byte enables; ack returns zero data.
    ls_bus.req   = 1'b1;
    ls_bus.we    = 1'b1;
    ls_bus.be    = 4'b0011;
    ls_bus.addr  = 32'h0000_2000;
    ls_bus.wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("store ls_gnt", 64'(ls_bus.gnt), 64'd1);
    check_eq("store mem_we", 64'(mem_bus.we), 64'd1);
    check_eq("store mem_be", 64'(mem_bus.be), 64'h3);
    check_eq("store mem_addr", 64'(mem_bus.addr), 64'h2000);
    check_eq("store mem_wdata", 64'(mem_bus.wdata), 64'hDEAD_BEEF);
    step();
    ls_bus.req     = 1'b0;
    ls_bus.we      = 1'b0;
    ls_bus.be      = 4'hF;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hFFFF_FFFF;
    #1;
    check_eq("store ls_rvalid", 64'(ls_bus.rvalid), 64'd1);
    check_eq("store ls_rdata", 64'(ls_bus.rdata), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    // Starvation guard: LS x4, then IF, then LS; each response returns the next cycle.
    if_bus.req     = 1'b1;
    if_bus.addr    = 32'h0000_0200;
    ls_bus.req     = 1'b1;
    ls_bus.addr    = 32'h0000_4000;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h0000_0077;
    for (int i = 0; i < 6; i++) begin
      logic exp_ls;
      logic prev_ls;
      exp_ls  = (i != 4);
      prev_ls = (i - 1 != 4);
      #1;
      check_eq($sformatf("starve%0d ls_gnt", i), 64'(ls_bus.gnt), 64'(exp_ls));
      check_eq($sformatf("starve%0d if_gnt", i), 64'(if_bus.gnt), 64'(!exp_ls));
      check_eq($sformatf("starve%0d hold", i), 64'(hold_flag), 64'(exp_ls));
      check_eq($sformatf("starve%0d ls_rvalid", i), 64'(ls_bus.rvalid), 64'((i > 0) && prev_ls));
      check_eq($sformatf("starve%0d if_rvalid", i), 64'(if_bus.rvalid), 64'((i > 0) && !prev_ls));
      @(posedge clk);
    end
    #1;
    if_bus.req = 1'b0;
    ls_bus.req = 1'b0;
    #1;
    check_eq("starve tail ls_rvalid", 64'(ls_bus.rvalid), 64'd1);
    check_eq("starve tail mem_req", 64'(mem_bus.req), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    // Back-pressure: memory refuses for three cycles.
    if_bus.req  = 1'b1;
    if_bus.addr = 32'h0000_0400;
    mem_bus.gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp%0d mem_req", i), 64'(mem_bus.req), 64'd1);
      check_eq($sformatf("bp%0d mem_addr", i), 64'(mem_bus.addr), 64'h400);
      check_eq($sformatf("bp%0d if_gnt", i), 64'(if_bus.gnt), 64'd0);
      check_eq($sformatf("bp%0d hold", i), 64'(hold_flag), 64'd1);
      step();
    end
    mem_bus.gnt = 1'b1;
    #1;
    check_eq("bp if_gnt", 64'(if_bus.gnt), 64'd1);
    check_eq("bp hold", 64'(hold_flag), 64'd0);
    step();
    if_bus.req     = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h1357_9BDF;
    #1;
    check_eq("bp if_rvalid", 64'(if_bus.rvalid), 64'd1);
    check_eq("bp if_rdata", 64'(if_bus.rdata), 64'h1357_9BDF);
    step();

    // A stray response while idle is ignored.
    #1;
    check_eq("idle if_rvalid", 64'(if_bus.rvalid), 64'd0);
    check_eq("idle ls_rvalid", 64'(ls_bus.rvalid), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    // Reset while a load is outstanding discards its response.
    ls_bus.req  = 1'b1;
    ls_bus.addr = 32'h0000_5000;
    #1;
    check_eq("midrst ls_gnt", 64'(ls_bus.gnt), 64'd1);
    step();
    ls_bus.req = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    rst = 1'b1;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hCAFE_F00D;
    #1;
    check_eq("midrst ls_rvalid", 64'(ls_bus.rvalid), 64'd0);
    check_eq("midrst if_rvalid", 64'(if_bus.rvalid), 64'd0);
    check_eq("midrst ls_rdata", 64'(ls_bus.rdata), 64'd0);
    step();
    mem_bus.rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
